// File: rtl/zbus_if.sv
// Z80-bus initiator signal bundle: command side (req/ack) plus the Z80 bus pins.
// The master modport is the initiator's view; the slave modport is the sequencer/bus-model view.
interface zbus_if;
    logic        req;
    logic        rnw;
    logic        mem;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] za;
    logic [7:0]  zd_out;
    logic        zd_oe;
    logic [7:0]  zd_in;
    logic        zmreq_n;
    logic        ziorq_n;
    logic        zrd_n;
    logic        zwr_n;
    logic        zwait_n;

    modport master (
        input  req, rnw, mem, addr, wdata, zd_in, zwait_n,
        output busy, ack, err, rdata, za, zd_out, zd_oe,
        output zmreq_n, ziorq_n, zrd_n, zwr_n
    );

    modport slave (
        output req, rnw, mem, addr, wdata, zd_in, zwait_n,
        input  busy, ack, err, rdata, za, zd_out, zd_oe,
        input  zmreq_n, ziorq_n, zrd_n, zwr_n
    );
endinterface

// File: rtl/zbus_master.sv
// Z80-bus initiator: runs one T1/T2/TW/T3 memory or I/O cycle per accepted command.
// Every bus output comes straight from a flop, so strobes cannot glitch.
module zbus_master #(
    parameter int unsigned IO_WAIT  = 1,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic   clk,
    input  logic   rst_n,
    zbus_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TW,
        S_T3
    } state_t;

    localparam logic [1:0] AUTO_IO  = 2'(IO_WAIT);
    localparam logic [7:0] TMO_LAST = 8'(WAIT_MAX - 1);

    state_t      r_state;
    logic        r_rnw;
    logic        r_mem;
    logic [1:0]  r_auto;
    logic [7:0]  r_tmo;
    logic        r_busy;
    logic        r_ack;
    logic        r_err;
    logic [7:0]  r_rdata;
    logic [15:0] r_za;
    logic [7:0]  r_zd_out;
    logic        r_zd_oe;
    logic        r_zmreq_n;
    logic        r_ziorq_n;
    logic        r_zrd_n;
    logic        r_zwr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rnw     <= 1'b1;
            r_mem     <= 1'b1;
            r_auto    <= 2'd0;
            r_tmo     <= 8'd0;
            r_busy    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 8'd0;
            r_za      <= 16'd0;
            r_zd_out  <= 8'd0;
            r_zd_oe   <= 1'b0;
            r_zmreq_n <= 1'b1;
            r_ziorq_n <= 1'b1;
            r_zrd_n   <= 1'b1;
            r_zwr_n   <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_rnw   <= bus.rnw;
                        r_mem   <= bus.mem;
                        r_za    <= bus.addr;
                        r_zd_oe <= ~bus.rnw;
                        if (!bus.rnw) r_zd_out <= bus.wdata;
                        r_auto  <= bus.mem ? 2'd0 : AUTO_IO;
                        r_tmo   <= 8'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_T1;
                    end
                end
                S_T1: begin
                    r_zmreq_n <= ~r_mem;
                    r_ziorq_n <= r_mem;
                    r_zrd_n   <= ~r_rnw;
                    r_zwr_n   <= r_rnw;
                    r_state   <= S_T2;
                end
                S_T2: begin
                    // r_auto is only ever non-zero for I/O cycles
                    if (r_auto != 2'd0 || !bus.zwait_n) r_state <= S_TW;
                    else                                r_state <= S_T3;
                end
                S_TW: begin
                    if (r_auto != 2'd0) begin
                        r_auto <= r_auto - 2'd1;
                        if (r_auto == 2'd1 && bus.zwait_n) r_state <= S_T3;
                    end else if (bus.zwait_n) begin
                        r_state <= S_T3;
                    end else if (r_tmo == TMO_LAST) begin
                        // wait timeout: release the bus, report err, leave rdata alone
                        r_zmreq_n <= 1'b1;
                        r_ziorq_n <= 1'b1;
                        r_zrd_n   <= 1'b1;
                        r_zwr_n   <= 1'b1;
                        r_zd_oe   <= 1'b0;
                        r_busy    <= 1'b0;
                        r_ack     <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_T3: begin
                    if (r_rnw) r_rdata <= bus.zd_in;
                    r_zmreq_n <= 1'b1;
                    r_ziorq_n <= 1'b1;
                    r_zrd_n   <= 1'b1;
                    r_zwr_n   <= 1'b1;
                    r_zd_oe   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ack     <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.ack     = r_ack;
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
    assign bus.za      = r_za;
    assign bus.zd_out  = r_zd_out;
    assign bus.zd_oe   = r_zd_oe;
    assign bus.zmreq_n = r_zmreq_n;
    assign bus.ziorq_n = r_ziorq_n;
    assign bus.zrd_n   = r_zrd_n;
    assign bus.zwr_n   = r_zwr_n;

endmodule
